ahb_rr_arbiter: RTL and testbench

- Round-robin AHB bus arbiter with lock support, handover on retry/split, and an optional tenure limit.
- Shares the single AHB master port of the bus fabric between N masters.
- Drives HGRANT per master plus HMASTER/HMASTLOCK toward the M2S mux and slaves.
- Index 0 is the default (park) master, as in the existing fabric.

---
 rtl/ahb_rr_arbiter.sv | 99 +++++++++
 tb/tb_ahb_rr_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB arbiter with lock and retry/split handover.
// Define ARB_TENURE_LIMIT_EN to force re-arbitration after MAX_TENURE NONSEQ transfers.
module ahb_rr_arbiter #(
  parameter int N              = 3,
  parameter int MST_W          = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [N-1:0]     HBUSREQ,
  input  logic [N-1:0]     HLOCK,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  input  logic [1:0]       HRESP,
  output logic [N-1:0]     HGRANT,
  output logic [MST_W-1:0] HMASTER,
  output logic             HMASTLOCK
);
  typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;
  localparam logic [MST_W-1:0] DEF     = MST_W'(DEFAULT_MASTER);
  localparam logic [MST_W-1:0] PTR_RST = MST_W'((DEFAULT_MASTER + 1) % N);
  localparam logic [N-1:0]     ONE     = N'(1);
  state_t state, state_n;
  logic [MST_W-1:0] ptr, win, gidx;
  logic [N-1:0] masked, req;
  logic retry, found, arb, own_req, own_lock, tenure_hit;
  assign retry    = HRESP[1];
  assign own_req  = |(HBUSREQ & HGRANT);
  assign own_lock = |(HLOCK & HGRANT);
  // a retried/split owner sits out one decision unless nobody else wants the bus
  assign masked = HBUSREQ & ~(retry ? HGRANT : '0);
  assign req    = (|masked) ? masked : HBUSREQ;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) gidx = HGRANT[i] ? MST_W'(i) : gidx;
  end
  // scan downward so the requester closest above ptr is the last one written
  always_comb begin
    win = DEF;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      for (int j = 0; j < N; j++)
        if (req[j] && (int'(ptr) + i == j || int'(ptr) + i == j + N)) begin
          win = MST_W'(j);
          found = 1'b1;
        end
  end
`ifdef ARB_TENURE_LIMIT_EN
  localparam int TW = $clog2(MAX_TENURE + 1);
  logic [TW-1:0] tenure;
  logic unused_ok;
  always_ff @(posedge HCLK)
    if (HRESET) tenure <= '0;
    else if (HREADY)
      tenure <= (gidx != HMASTER) ? '0 :
                (HTRANS == 2'b10 && tenure != TW'(MAX_TENURE)) ? tenure + 1'b1 : tenure;
  // only the owner already in the address phase can expire, and only between bursts
  assign tenure_hit = tenure == TW'(MAX_TENURE) && gidx == HMASTER &&
                      |(HBUSREQ & ~HGRANT) && !HTRANS[0];
  assign unused_ok  = HRESP[0];
`else
  logic unused_ok;
  assign tenure_hit = 1'b0;
  assign unused_ok  = ^{HRESP[0], HTRANS, MAX_TENURE != 0};
`endif
  always_comb begin
    state_n = state;
    arb = 1'b0;
    if (HREADY) begin
      if (state == PARK) arb = |HBUSREQ;
      else if (retry) arb = 1'b1;
      else if (own_lock) state_n = LOCKED;
      else if (state == LOCKED) begin
        state_n = OWN;
        arb = !own_req;
      end else arb = !own_req || tenure_hit;
      if (arb) state_n = found ? OWN : PARK;
    end
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state     <= PARK;
      HGRANT    <= ONE << DEF;
      ptr       <= PTR_RST;
      HMASTER   <= DEF;
      HMASTLOCK <= 1'b0;
    end else begin
      state <= state_n;
      if (arb) begin
        HGRANT <= ONE << win;
        ptr    <= (win == MST_W'(N - 1)) ? '0 : win + 1'b1;
      end
      if (HREADY) begin
        HMASTER   <= gidx;
        HMASTLOCK <= own_lock && !retry;
      end
    end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: vector table plus hand sequences, checked through an expected-output queue.
module tb_ahb_rr_arbiter;
  localparam int N = 3;
  localparam int MST_W = 4;
  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10;
  localparam logic [1:0] OK = 2'b00, RTY = 2'b10, SPL = 2'b11;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic HREADY = 1'b1;
  logic [N-1:0] HBUSREQ = '0, HLOCK = '0;
  logic [1:0] HTRANS = IDLE, HRESP = OK;
  logic [N-1:0] HGRANT;
  logic [MST_W-1:0] HMASTER;
  logic HMASTLOCK;
  typedef struct {
    logic rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [1:0] trans;
    logic ready;
    logic [1:0] resp;
    logic [N-1:0] g;
    logic [MST_W-1:0] m;
    logic ml;
  } vec_t;
  typedef struct {
    logic [N-1:0] g;
    logic [MST_W-1:0] m;
    logic ml;
  } exp_t;
  vec_t tbl[$];
  exp_t exp_q[$];
  int checks = 0, errors = 0, step = 0;
  logic [N-1:0] tg;
  logic [MST_W-1:0] tm;

  ahb_rr_arbiter #(.N(N), .MST_W(MST_W), .DEFAULT_MASTER(0), .MAX_TENURE(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRESP(HRESP), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lock,
                              input logic [1:0] trans, input logic ready, input logic [1:0] resp,
                              input logic [N-1:0] g, input logic [MST_W-1:0] m, input logic ml);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.ready = ready;
    v.resp = resp; v.g = g; v.m = m; v.ml = ml;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL step %0d %s: got %0h expected %0h", step, name, act, exp_v);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge HCLK);
    HRESET = v.rst; HBUSREQ = v.req; HLOCK = v.lock; HTRANS = v.trans;
    HREADY = v.ready; HRESP = v.resp;
    exp_q.push_back('{v.g, v.m, v.ml});
    @(posedge HCLK);
    #1;
    step++;
    e = exp_q.pop_front();
    chk("HGRANT", 32'(HGRANT), 32'(e.g));
    chk("HMASTER", 32'(HMASTER), 32'(e.m));
    chk("HMASTLOCK", 32'(HMASTLOCK), 32'(e.ml));
    chk("grant_onehot", 32'($onehot(HGRANT)), 32'd1);
    chk("master_range", 32'(HMASTER < MST_W'(N)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, step %0d", step);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(1, 3'b000, 3'b000, IDLE, 1, OK, 3'b001, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3'b000, 3'b000, IDLE, 1, OK, 3'b001, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 1, 0));
    tbl.push_back(mk(0, 3'b110, 3'b000, IDLE, 1, OK, 3'b010, 1, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 1, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 0, OK, 3'b010, 1, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 1, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b010, IDLE, 1, OK, 3'b010, 1, 1));
    tbl.push_back(mk(0, 3'b110, 3'b010, IDLE, 1, OK, 3'b010, 1, 1));
    tbl.push_back(mk(0, 3'b100, 3'b010, IDLE, 1, OK, 3'b010, 1, 1));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 1, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 2, 0));
    tbl.push_back(mk(0, 3'b110, 3'b010, IDLE, 1, OK, 3'b010, 1, 1));
    tbl.push_back(mk(0, 3'b110, 3'b010, IDLE, 1, RTY, 3'b100, 1, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, IDLE, 1, OK, 3'b100, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 2, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 1, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, RTY, 3'b010, 1, 0));
    tbl.push_back(mk(0, 3'b110, 3'b000, IDLE, 1, SPL, 3'b100, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, IDLE, 1, OK, 3'b001, 2, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, IDLE, 1, OK, 3'b001, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, IDLE, 1, OK, 3'b001, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, IDLE, 1, OK, 3'b001, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);
    apply(mk(0, 3'b010, 3'b000, IDLE, 1, OK, 3'b010, 0, 0));
    apply(mk(0, 3'b110, 3'b000, IDLE, 1, OK, 3'b010, 1, 0));
    for (int k = 1; k <= 20; k++) begin
`ifdef ARB_TENURE_LIMIT_EN
      tg = (k >= 9 && k <= 18) ? 3'b100 : 3'b010;
      tm = (k >= 10 && k <= 19) ? MST_W'(2) : MST_W'(1);
`else
      tg = 3'b010;
      tm = MST_W'(1);
`endif
      apply(mk(0, 3'b110, 3'b000, NSQ, 1, OK, tg, tm, 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
